// File: rtl/board_pkg.sv
// board_pkg: opcodes, instruction field positions and program ROM images for the course CPU.
package board_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam int OP_HI = 15, OP_LO = 12;
  localparam int RD_HI = 11, RD_LO = 10;
  localparam int RS_HI = 9,  RS_LO = 8;
  localparam int IMM_HI = 7, IMM_LO = 0;
  // prog 0 is the LED up-counter; prog 1 is the decrement/halt check program
  function automatic logic [15:0] rom_image(input int prog, input logic [7:0] a);
    if (prog == 1)
      return a == 8'd0 ? 16'h1800 : a == 8'd1 ? 16'h7AFF : a == 8'd2 ? 16'h9005 :
             a == 8'd3 ? 16'hB800 : a == 8'd4 ? 16'hF000 : 16'h0000;
    return a == 8'd0 ? 16'h1000 : a == 8'd1 ? 16'h1401 : a == 8'd2 ? 16'h2100 :
           a == 8'd3 ? 16'hB000 : a == 8'd4 ? 16'h8002 : 16'h0000;
  endfunction
endpackage

// File: rtl/board_if.sv
// board_if: fetch bus between the divider/ROM side and the CPU core.
interface board_if;
  logic        cpu_en;
  logic [15:0] instr;
  logic [7:0]  pc;
  modport master(output cpu_en, output instr, input pc);
  modport slave(input cpu_en, input instr, output pc);
endinterface

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 16-bit CPU with four registers, Z flag, halt and LED output register.
module cpu_core
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  board_if.slave     bus,
  output logic [7:0] led_o
);
  logic [7:0] pc_q, pc_d, led_q, led_d;
  logic [3:0][15:0] r_q, r_d;
  logic z_q, z_d, h_q, h_d;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic [15:0] a, b, res;
  logic wr, zu, jmp;
  assign op  = bus.instr[OP_HI:OP_LO];
  assign rd  = bus.instr[RD_HI:RD_LO];
  assign rs  = bus.instr[RS_HI:RS_LO];
  assign imm = bus.instr[IMM_HI:IMM_LO];
  assign a   = r_q[rd];
  assign b   = r_q[rs];
  always_comb begin
    res = 16'h0000;
    wr = 1'b0;
    zu = 1'b0;
    jmp = 1'b0;
    case (op)
      OP_LDI:  begin res = {8'h00, imm}; wr = 1'b1; end
      OP_ADD:  begin res = a + b; wr = 1'b1; zu = 1'b1; end
      OP_SUB:  begin res = a - b; wr = 1'b1; zu = 1'b1; end
      OP_AND:  begin res = a & b; wr = 1'b1; zu = 1'b1; end
      OP_OR:   begin res = a | b; wr = 1'b1; zu = 1'b1; end
      OP_XOR:  begin res = a ^ b; wr = 1'b1; zu = 1'b1; end
      OP_ADDI: begin res = a + {{8{imm[7]}}, imm}; wr = 1'b1; zu = 1'b1; end
      OP_JMP:  jmp = 1'b1;
      OP_JZ:   jmp = z_q;
      OP_JNZ:  jmp = !z_q;
      OP_NOP:  ;
      default: ;
    endcase
  end
  always_comb begin
    pc_d = pc_q;
    r_d = r_q;
    z_d = z_q;
    h_d = h_q;
    led_d = led_q;
    if (bus.cpu_en && !h_q) begin
      pc_d = op == OP_HLT ? pc_q : jmp ? imm : pc_q + 8'd1;
      h_d = op == OP_HLT;
      if (wr) r_d[rd] = res;
      if (zu) z_d = res == 16'h0000;
      if (op == OP_OUT) led_d = a[7:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      r_q <= '0;
      z_q <= 1'b0;
      h_q <= 1'b0;
      led_q <= '0;
    end else begin
      pc_q <= pc_d;
      r_q <= r_d;
      z_q <= z_d;
      h_q <= h_d;
      led_q <= led_d;
    end
  end
  assign bus.pc = pc_q;
  assign led_o = led_q;
endmodule

// File: rtl/board_test_top.sv
// board_test_top: course CPU with clock-enable divider, combinational program ROM and LED port.
module board_test_top
  import board_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ROM_DEPTH = 256,
  parameter int PROG      = 0
) (
  input  logic       clk_undiv,
  input  logic       rst,
  output logic [7:0] led
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  board_if bus();
  assign bus.cpu_en = cnt_q == CW'(CLK_DIV - 1);
  assign cnt_d = bus.cpu_en ? '0 : cnt_q + CW'(1);
  assign bus.instr = 32'(bus.pc) < ROM_DEPTH ? rom_image(PROG, bus.pc) : 16'h0000;
  always_ff @(posedge clk_undiv) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  cpu_core u_core (
    .clk  (clk_undiv),
    .rst  (rst),
    .bus  (bus),
    .led_o(led)
  );
endmodule

// File: tb/tb_board_test_top.sv
// tb_board_test_top: ISA-level model of three board configurations checked every cycle, plus literal LED timing points.
module tb_board_test_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] led0, led1, led2;
  logic [7:0] dled[3];
  logic [7:0] dpc[3];
  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  always #5 clk = ~clk;
  board_test_top #(.CLK_DIV(4)) u0 (.clk_undiv(clk), .rst(rst), .led(led0));
  board_test_top #(.CLK_DIV(1)) u1 (.clk_undiv(clk), .rst(rst), .led(led1));
  board_test_top #(.CLK_DIV(4), .PROG(1)) u2 (.clk_undiv(clk), .rst(rst), .led(led2));
  board_if mon();
  assign mon.pc = u0.bus.pc;
  assign mon.cpu_en = u0.bus.cpu_en;
  assign mon.instr = u0.bus.instr;
  assign dled[0] = led0;
  assign dled[1] = led1;
  assign dled[2] = led2;
  assign dpc[0] = u0.bus.pc;
  assign dpc[1] = u1.bus.pc;
  assign dpc[2] = u2.bus.pc;
  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] led;
    logic [3:0][15:0] r;
    logic z;
    logic h;
    logic [31:0] n;
  } st_t;
  st_t m[3];
  function automatic logic [15:0] trom(input int sel, input logic [7:0] a);
    if (sel == 1)
      case (a)
        8'd0: return 16'h1800;
        8'd1: return 16'h7AFF;
        8'd2: return 16'h9005;
        8'd3: return 16'hB800;
        8'd4: return 16'hF000;
        default: return 16'h0000;
      endcase
    case (a)
      8'd0: return 16'h1000;
      8'd1: return 16'h1401;
      8'd2: return 16'h2100;
      8'd3: return 16'hB000;
      8'd4: return 16'h8002;
      default: return 16'h0000;
    endcase
  endfunction
  // one board edge: count edges since reset, run an instruction on every div-th edge
  function automatic st_t step(input st_t s, input int sel, input int div);
    logic [15:0] w;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [15:0] sx;
    s.n = s.n + 32'd1;
    if ((s.n % div) != 0 || s.h) return s;
    w = trom(sel, s.pc);
    op = w[15:12];
    rd = w[11:10];
    rs = w[9:8];
    sx = {{8{w[7]}}, w[7:0]};
    s.pc = s.pc + 8'd1;
    case (op)
      4'h1: s.r[rd] = {8'h00, w[7:0]};
      4'h2: s.r[rd] = s.r[rd] + s.r[rs];
      4'h3: s.r[rd] = s.r[rd] - s.r[rs];
      4'h4: s.r[rd] = s.r[rd] & s.r[rs];
      4'h5: s.r[rd] = s.r[rd] | s.r[rs];
      4'h6: s.r[rd] = s.r[rd] ^ s.r[rs];
      4'h7: s.r[rd] = s.r[rd] + sx;
      4'h8: s.pc = w[7:0];
      4'h9: if (s.z) s.pc = w[7:0];
      4'hA: if (!s.z) s.pc = w[7:0];
      4'hB: s.led = s.r[rd][7:0];
      4'hF: begin s.h = 1'b1; s.pc = s.pc - 8'd1; end
      default: ;
    endcase
    if (op >= 4'h2 && op <= 4'h7) s.z = s.r[rd] == 16'h0000;
    return s;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      m[i] <= rst ? '0 : step(m[i], i == 2 ? 1 : 0, i == 1 ? 1 : 4);
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_led%0d", k), {8'h00, dled[k]}, {8'h00, m[k].led});
      chk($sformatf("model_pc%0d", k), {8'h00, dpc[k]}, {8'h00, m[k].pc});
    end
  task automatic adv(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask
  initial begin
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_led", {8'h00, led0}, 16'h0000);
    chk("rst_pc", {8'h00, mon.pc}, 16'h0000);
    rst = 1'b0;
    e = 0;
    adv(4);
    chk("div1_led_e4", {8'h00, led1}, 16'h0001);
    adv(7);
    chk("div1_led_e7", {8'h00, led1}, 16'h0002);
    adv(15);
    chk("div4_led_e15", {8'h00, led0}, 16'h0000);
    adv(16);
    chk("div4_led_e16", {8'h00, led0}, 16'h0001);
    adv(28);
    chk("div4_led_e28", {8'h00, led0}, 16'h0002);
    adv(40);
    chk("div4_led_e40", {8'h00, led0}, 16'h0003);
    adv(64);
    chk("div4_led_e64", {8'h00, led0}, 16'h0005);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_led0", {8'h00, led0}, 16'h0000);
    chk("midrst_led1", {8'h00, led1}, 16'h0000);
    chk("midrst_pc", {8'h00, mon.pc}, 16'h0000);
    rst = 1'b0;
    e = 0;
    adv(16);
    chk("restart_led_e16", {8'h00, led0}, 16'h0001);
    adv(100);
    chk("prog1_led", {8'h00, led2}, 16'h00FF);
    chk("prog1_pc_frozen", {8'h00, u2.bus.pc}, 16'h0004);
    adv(766);
    chk("wrap_led_ff", {8'h00, led1}, 16'h00FF);
    adv(769);
    chk("wrap_led_00", {8'h00, led1}, 16'h0000);
    adv(772);
    chk("wrap_led_01", {8'h00, led1}, 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
